// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side stream drainer.
package fifo_pkg;

  localparam int FIFO_RD_BUF_DEPTH = 3;
  localparam int FIFO_RD_PTR_W     = 2;
  localparam int FIFO_RD_CNT_W     = 32;

  // Advance a prefetch-buffer pointer, wrapping after the last entry.
  function automatic logic [FIFO_RD_PTR_W-1:0] ptr_inc(input logic [FIFO_RD_PTR_W-1:0] p);
    if (p == FIFO_RD_PTR_W'(FIFO_RD_BUF_DEPTH - 1)) begin
      return '0;
    end
    return p + FIFO_RD_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops words from a synchronous FIFO with one-cycle registered
// read latency and re-presents them as a valid/ready stream. A 3-entry
// prefetch buffer plus an in-flight credit hides the read latency so the
// stream sustains one beat per cycle.
// Optional feature: define FIFO_RD_STREAM_CNT_EN to add the beat_cnt port
// and its 32-bit accepted-beat counter.
//
// Handshake: a beat transfers on every rising edge where m_valid && m_ready.
// Once m_valid rises, m_valid and m_data hold until that edge; m_ready may
// toggle freely and has no effect while m_valid is low. fifo_rden depends
// only on registered state, fifo_empty and reset, never on m_ready.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             asrst_n,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_rddata,
  input  logic             fifo_empty,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [FIFO_RD_CNT_W-1:0] beat_cnt
`endif
);

  logic [WIDTH-1:0]         buf_q [FIFO_RD_BUF_DEPTH];
  logic [FIFO_RD_PTR_W-1:0] hd_q;
  logic [FIFO_RD_PTR_W-1:0] tl_q;
  logic [FIFO_RD_PTR_W-1:0] occ_q;
  logic [FIFO_RD_PTR_W-1:0] occ_d;
  logic                     infl_q;
  logic [FIFO_RD_PTR_W:0]   credit_used;
  logic                     capture;
  logic                     pop;

  // Credits in use: buffered words plus the word the FIFO is returning now.
  assign credit_used = {1'b0, occ_q} + {{FIFO_RD_PTR_W{1'b0}}, infl_q};

  // Only issue a read when the buffer is guaranteed room for its data.
  assign fifo_rden = asrst_n && !fifo_empty &&
                     (credit_used < (FIFO_RD_PTR_W + 1)'(FIFO_RD_BUF_DEPTH));

  assign capture = infl_q;
  assign m_valid = (occ_q != '0);
  assign m_data  = buf_q[hd_q];
  assign pop     = m_valid && m_ready;

  // Occupancy moves by one only when exactly one of capture/pop happens.
  always_comb begin
    occ_d = occ_q;
    case ({capture, pop})
      2'b10:   occ_d = occ_q + FIFO_RD_PTR_W'(1);
      2'b01:   occ_d = occ_q - FIFO_RD_PTR_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Buffer, pointers, occupancy and in-flight flag.
  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      for (int i = 0; i < FIFO_RD_BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      hd_q   <= '0;
      tl_q   <= '0;
      occ_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= fifo_rden;
      if (capture) begin
        buf_q[tl_q] <= fifo_rddata;
        tl_q        <= ptr_inc(tl_q);
      end
      if (pop) begin
        hd_q <= ptr_inc(hd_q);
      end
      occ_q <= occ_d;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [FIFO_RD_CNT_W-1:0] beat_cnt_q;

  // Accepted-beat counter; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      beat_cnt_q <= '0;
    end else if (pop) begin
      beat_cnt_q <= beat_cnt_q + FIFO_RD_CNT_W'(1);
    end
  end

  assign beat_cnt = beat_cnt_q;
`else
  // No beat counter in this build.
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model on the read port,
// directed stimulus, scoreboard queue checked by a negedge monitor.
// Define FIFO_RD_STREAM_CNT_EN to also exercise beat_cnt.
module tb_fifo_rd_stream;

  localparam int W = 8;

  logic         clk;
  logic         asrst_n;
  logic         fifo_rden;
  logic [W-1:0] fifo_rddata;
  logic         fifo_empty;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]  beat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  // FIFO model storage
  logic [W-1:0] mem [4096];
  int wr_idx = 0;
  int rd_idx = 0;

  // monitor state
  int           issued   = 0;
  int           accepted = 0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  fifo_rd_stream #(.WIDTH(W)) dut (
    .clk         (clk),
    .asrst_n     (asrst_n),
    .fifo_rden   (fifo_rden),
    .fifo_rddata (fifo_rddata),
    .fifo_empty  (fifo_empty),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt    (beat_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model ----------------
  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge clk or negedge asrst_n) begin
    if (!asrst_n) begin
      rd_idx      <= wr_idx;
      fifo_rddata <= '0;
    end else if (fifo_rden && !fifo_empty) begin
      fifo_rddata <= mem[rd_idx % 4096];
      rd_idx      <= rd_idx + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push_word(input logic [W-1:0] v);
    mem[wr_idx % 4096] = v;
    exp_q.push_back(v);
    wr_idx++;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!asrst_n) begin
      issued    = 0;
      accepted  = 0;
      prev_hold = 1'b0;
    end else begin
      total++;
      if (issued - accepted > 3) begin
        bad++;
        $display("FAIL credit: got occ+infl=%0d want <=3", issued - accepted);
      end
      if (prev_hold) begin
        total++;
        if (!m_valid || m_data !== prev_data) begin
          bad++;
          $display("FAIL hold: got valid=%0b data=%0h want valid=1 data=%0h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: got data=%0h want no beat", m_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            bad++;
            $display("FAIL beat_data: got %0h want %0h", m_data, e);
          end
        end
        accepted++;
      end
      if (fifo_rden) issued++;
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int gaps;
    int pulses;
    int n;

    asrst_n = 1'b0;
    m_ready = 1'b0;

    // reset values
    #1;
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_rden",  64'(fifo_rden), 64'd0);
    check("rst_data",  64'(m_data), 64'd0);
    repeat (3) @(negedge clk);
    asrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_rden", 64'(fifo_rden), 64'd0);
    end

    // single word
    @(posedge clk); #1;
    m_ready = 1'b1;
    push_word(8'hA5);
    @(negedge clk);
    check("sw_rden_c0", 64'(fifo_rden), 64'd1);
    check("sw_valid_c0", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("sw_rden_c1", 64'(fifo_rden), 64'd0);
    check("sw_valid_c1", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("sw_valid_c2", 64'(m_valid), 64'd1);
    check("sw_data_c2", 64'(m_data), 64'hA5);
    @(posedge clk); #1;
    check("sw_valid_after", 64'(m_valid), 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("sw_beat_cnt", 64'(beat_cnt), 64'd1);
`endif

    // streaming 192 words, ready held high
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 192; i++) push_word(W'(i));
    @(negedge clk);
    check("st_valid_c0", 64'(m_valid), 64'd0);
    @(negedge clk);
    check("st_valid_c1", 64'(m_valid), 64'd0);
    gaps = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (!m_valid) gaps++;
    end
    check("st_gaps", 64'(gaps), 64'd0);
    @(negedge clk);
    check("st_valid_end", 64'(m_valid), 64'd0);
    wait_drain("st_drain", 10);

    // back-pressure: 10 words, ready low
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_word(W'(i));
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_rden) pulses++;
    end
    check("bp_pulses", 64'(pulses), 64'd3);
    check("bp_rden_low", 64'(fifo_rden), 64'd0);
    check("bp_valid", 64'(m_valid), 64'd1);
    check("bp_head", 64'(m_data), 64'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // random ready over 1000 words
    @(posedge clk); #1;
    for (int i = 0; i < 1000; i++) push_word(W'(i) ^ 8'h5A);
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge clk); #1;
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1'b1;
    wait_drain("rnd_drain", 20);

    // reset mid-transfer
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h11 + W'(i));
    repeat (5) @(negedge clk);
    check("mr_valid_pre", 64'(m_valid), 64'd1);
    @(posedge clk); #3;
    asrst_n = 1'b0;
    #1;
    check("mr_valid", 64'(m_valid), 64'd0);
    check("mr_rden",  64'(fifo_rden), 64'd0);
    check("mr_data",  64'(m_data), 64'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("mr_beat_cnt", 64'(beat_cnt), 64'd0);
`endif
    exp_q.delete();
    repeat (2) @(negedge clk);
    asrst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mr_idle_rden", 64'(fifo_rden), 64'd0);
      check("mr_idle_valid", 64'(m_valid), 64'd0);
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    // counter wrap
    @(posedge clk); #1;
    force dut.beat_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.beat_cnt_q;
    check("cw_forced", 64'(beat_cnt), 64'hFFFF_FFFE);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(8'hC0 + W'(i));
    for (int k = 0; k < 3; k++) begin
      logic [31:0] want;
      want = 32'hFFFF_FFFF + 32'(k);
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("cw_valid", 64'(m_valid), 64'd1);
      @(posedge clk); #1;
      check("cw_beat_cnt", 64'(beat_cnt), 64'(want));
    end
    wait_drain("cw_drain", 10);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
